rv32_mc_ctrl: RTL and testbench

Multicycle RV32I control unit. Sequences fetch/decode/execute/writeback over a shared ALU, memory port and the immediate extender. Drives imm_src, mux selects, write enables and memory requests from the current opcode and state. Sits beside the datapath, one instruction in flight.

---
 rtl/rv32_ctrl_pkg.sv | 84 ++++++++
 rtl/rv32_alu_dec.sv | 35 +++
 rtl/rv32_mc_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rv32_mc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM state codes,
// base opcodes, immediate formats, ALU operations and datapath select codes.
package rv32_ctrl_pkg;

   // FSM state codes (4-bit, legacy-compatible constants)
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECR    = 4'd6;
   localparam state_t S_EXECI    = 4'd7;
   localparam state_t S_ALUWB    = 4'd8;
   localparam state_t S_BRANCH   = 4'd9;
   localparam state_t S_JAL      = 4'd10;
   localparam state_t S_JALR     = 4'd11;
   localparam state_t S_UIMM     = 4'd12;
   localparam state_t S_TRAP     = 4'd13;

   // base opcodes, instr[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // immediate extender formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // ALU operations
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // coarse ALU intent handed from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // result mux
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // ALU operand A mux
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B mux
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // true for every opcode the controller knows how to sequence
   function automatic logic op_legal(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR,
         OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv32_alu_dec.sv
// ALU decoder: maps the FSM's coarse ALU intent plus funct fields to a
// concrete ALU operation. Purely combinational.
module rv32_alu_dec
   import rv32_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alu_control
);

   // funct7b5 means sub only for register-register ops (op5 = 1); for
   // OP-IMM it is an immediate bit, except on shifts where it selects sra.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multicycle RV32I control unit. One instruction in flight; Moore outputs
// decoded from the state, with mem_ready, op and the ALU flags qualifying
// the few enables that depend on them.
// Optional retired-instruction counter: define RV32_CTRL_INSTRET_EN.
module rv32_mc_ctrl
   import rv32_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE  = S_FETCH,
   parameter bit         ILLEGAL_HALT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        lt,
   input  logic        ltu,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_write,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_control,
   output logic [2:0]  imm_src,
   output logic        illegal,
   output logic [31:0] instret
);

   state_t     state, state_nxt;
   logic [1:0] alu_op;
   logic       br_take;
   logic       mem_req_d, mem_write_d, ir_write_d, pc_write_d, reg_write_d;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RESET_STATE;
      else      state <= state_nxt;
   end

   // sticky illegal flag; set whenever an unknown opcode is decoded, so it
   // is also visible when illegal opcodes are being skipped as NOPs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    illegal <= 1'b0;
      else if (state == S_DECODE && !op_legal(op)) illegal <= 1'b1;
   end

   // branch condition from funct3; 010/011 are not branches and never take
   always_comb begin
      case (funct3)
         3'b000:  br_take = zero;
         3'b001:  br_take = !zero;
         3'b100:  br_take = lt;
         3'b101:  br_take = !lt;
         3'b110:  br_take = ltu;
         3'b111:  br_take = !ltu;
         default: br_take = 1'b0;
      endcase
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE:    state_nxt = S_MEMADR;
               OP_R:                 state_nxt = S_EXECR;
               OP_IMM:               state_nxt = S_EXECI;
               OP_BRANCH:            state_nxt = S_BRANCH;
               OP_JAL:               state_nxt = S_JAL;
               OP_JALR:              state_nxt = S_JALR;
               OP_LUI, OP_AUIPC:     state_nxt = S_UIMM;
               OP_FENCE, OP_SYSTEM:  state_nxt = S_FETCH;
               default:              state_nxt = ILLEGAL_HALT ? S_TRAP : S_FETCH;
            endcase
         end
         S_MEMADR:   state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
         S_MEMWB:    state_nxt = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
         S_EXECR:    state_nxt = S_ALUWB;
         S_EXECI:    state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JAL:      state_nxt = S_ALUWB;
         S_JALR:     state_nxt = S_JAL;
         S_UIMM:     state_nxt = S_ALUWB;
         S_TRAP:     state_nxt = S_TRAP;
         default:    state_nxt = S_FETCH;  // unused codes recover to fetch
      endcase
   end

   // per-state output decode; everything not listed stays at 0
   always_comb begin
      mem_req_d   = 1'b0;
      mem_write_d = 1'b0;
      ir_write_d  = 1'b0;
      pc_write_d  = 1'b0;
      reg_write_d = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;
      imm_src     = IMM_I;
      case (state)
         S_FETCH: begin
            mem_req_d  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            ir_write_d = mem_ready;
            pc_write_d = mem_ready;
         end
         S_DECODE: begin
            // speculatively form the branch/jump target into ALUOut
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            mem_req_d = 1'b1;
            adr_src   = 1'b1;
         end
         S_MEMWB: begin
            result_src  = RES_RDATA;
            reg_write_d = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_d   = 1'b1;
            mem_write_d = 1'b1;
            adr_src     = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write_d = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            pc_write_d = br_take;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms the link
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write_d = 1'b1;
         end
         S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_UIMM: begin
            alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = IMM_U;
         end
         default: ;  // TRAP and unused codes drive nothing
      endcase
   end

   // enables and memory strobes are forced low for as long as reset is held
   assign mem_req   = mem_req_d   & rst;
   assign mem_write = mem_write_d & rst;
   assign ir_write  = ir_write_d  & rst;
   assign pc_write  = pc_write_d  & rst;
   assign reg_write = reg_write_d & rst;

   rv32_alu_dec u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

`ifdef RV32_CTRL_INSTRET_EN
   logic [31:0] instret_q;

   // count every return to FETCH; TRAP never returns, so it never counts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                         instret_q <= '0;
      else if (state != S_FETCH && state_nxt == S_FETCH) instret_q <= instret_q + 32'd1;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Scoreboard bench for rv32_mc_ctrl: the stimulus process expands each
// instruction into its expected per-cycle control bundle and queues it;
// the monitor pops one bundle per cycle and compares it to the DUT.
module tb_rv32_mc_ctrl;

   logic        clk, rst;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5, zero, lt, ltu, mem_ready;
   logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic [3:0]  alu_control;
   logic [2:0]  imm_src;
   logic        illegal;
   logic [31:0] instret;

   rv32_mc_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
      .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
      logic [1:0]  result_src, alu_src_a, alu_src_b;
      logic [3:0]  alu_control;
      logic [2:0]  imm_src;
      logic        illegal;
      logic [31:0] instret;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    tests = 0, fails = 0, cyc = 0;
   int    icount = 0;   // instructions retired since last reset
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic       cur_f7, cur_z, cur_lt, cur_ltu;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, got, want);
      end
   endtask

   // monitor: one expected bundle per cycle while the scoreboard has entries
   initial begin
      obs_t  a, e;
      string t;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.mem_req = mem_req;       a.mem_write = mem_write; a.adr_src = adr_src;
            a.ir_write = ir_write;     a.pc_write = pc_write;   a.reg_write = reg_write;
            a.result_src = result_src; a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b;
            a.alu_control = alu_control; a.imm_src = imm_src;
            a.illegal = illegal;       a.instret = instret;
            check(t, 64'(a), 64'(e));
         end
      end
   end

   // quiet bundle: every enable and select low, current flag/counter values
   function automatic obs_t base();
      obs_t e;
      e = '0;
`ifdef RV32_CTRL_INSTRET_EN
      e.instret = icount;
`endif
      return e;
   endfunction

   function automatic logic [3:0] alu_ref(input logic rtype, input logic [2:0] f3, input logic f7);
      logic [3:0] m [8];
      m = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      if (f3 == 3'd0 && rtype && f7) return 4'd1;
      if (f3 == 3'd5 && f7)          return 4'd9;
      return m[f3];
   endfunction

   function automatic logic br_ref(input logic [2:0] f3, input logic z, input logic l, input logic lu);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return l;
         3'd5: return !l;
         3'd6: return lu;
         3'd7: return !lu;
         default: return 1'b0;
      endcase
   endfunction

   // start a new cycle: drive this cycle's inputs and queue its expectation
   task automatic push_cyc(input obs_t e, input logic mr, input string tag);
      @(posedge clk);
      #1;
      op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
      zero = cur_z; lt = cur_lt; ltu = cur_ltu;
      mem_ready = mr;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic aluwb();
      obs_t e;
      e = base(); e.reg_write = 1'b1;
      push_cyc(e, rnd_bit(), "aluwb");
   endtask

   task automatic jal_step();
      obs_t e;
      e = base(); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
      push_cyc(e, rnd_bit(), "jal");
   endtask

   // One instruction. fw/mw = wait cycles at fetch / data memory;
   // cut >= 0 stops after that many data-memory wait cycles (reset follows).
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input logic l, input logic lu,
                            input int fw, input int mw, input int cut);
      obs_t e;
      bit   retired;
      retired = 1'b1;
      cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lt = l; cur_ltu = lu;
      for (int i = 0; i <= fw; i++) begin
         e = base(); e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
         if (i == fw) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
         push_cyc(e, (i == fw), "fetch");
      end
      e = base(); e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
      e.imm_src = (o == 7'b1101111) ? 3'b100 : 3'b010;
      push_cyc(e, rnd_bit(), "decode");
      case (o)
         7'b0000011, 7'b0100011: begin
            e = base(); e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
            e.imm_src = (o == 7'b0100011) ? 3'b001 : 3'b000;
            push_cyc(e, rnd_bit(), "memadr");
            for (int i = 0; i <= mw; i++) begin
               if (cut >= 0 && i == cut) return;
               e = base(); e.mem_req = 1'b1; e.adr_src = 1'b1;
               e.mem_write = (o == 7'b0100011);
               push_cyc(e, (i == mw), (o == 7'b0100011) ? "memwrite" : "memread");
            end
            if (o == 7'b0000011) begin
               e = base(); e.result_src = 2'b01; e.reg_write = 1'b1;
               push_cyc(e, rnd_bit(), "memwb");
            end
         end
         7'b0110011, 7'b0010011: begin
            e = base(); e.alu_src_a = 2'b10;
            e.alu_src_b = (o == 7'b0010011) ? 2'b01 : 2'b00;
            e.alu_control = alu_ref(o == 7'b0110011, f3, f7);
            push_cyc(e, rnd_bit(), (o == 7'b0110011) ? "execr" : "execi");
            aluwb();
         end
         7'b1100011: begin
            e = base(); e.alu_src_a = 2'b10; e.alu_control = 4'd1;
            e.pc_write = br_ref(f3, z, l, lu);
            push_cyc(e, rnd_bit(), "branch");
         end
         7'b1101111: begin
            jal_step();
            aluwb();
         end
         7'b1100111: begin
            e = base(); e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
            push_cyc(e, rnd_bit(), "jalr");
            jal_step();
            aluwb();
         end
         7'b0110111, 7'b0010111: begin
            e = base(); e.alu_src_b = 2'b01; e.imm_src = 3'b011;
            e.alu_src_a = (o == 7'b0110111) ? 2'b11 : 2'b01;
            push_cyc(e, rnd_bit(), "uimm");
            aluwb();
         end
         7'b0001111, 7'b1110011: ;
         default: begin
            // parked: flag raised, nothing driven, no retirement
            retired = 1'b0;
            for (int i = 0; i < 4; i++) begin
               e = base(); e.illegal = 1'b1;
               push_cyc(e, rnd_bit(), "trap");
            end
         end
      endcase
      if (retired) icount++;
   endtask

   // asynchronous reset in mid-cycle, then release ahead of the next edge
   task automatic reset_mid();
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_async_enables", 64'({mem_req, mem_write, ir_write, pc_write, reg_write}), 64'd0);
      check("rst_async_flags", 64'({illegal, instret}), 64'd0);
      mem_ready = 1'b1;   // FETCH with a ready memory must still stay quiet
      @(posedge clk);
      #2;
      check("rst_held_enables", 64'({mem_req, mem_write, ir_write, pc_write, reg_write}), 64'd0);
      @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b1;
      icount = 0;
   endtask

   // watchdog
   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog: got timeout want completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      logic [6:0] ops [11];
      int k;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};
      rst = 1'b0; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
      zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0; cur_z = 1'b0; cur_lt = 1'b0; cur_ltu = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_enables", 64'({mem_req, mem_write, ir_write, pc_write, reg_write}), 64'd0);
      check("reset_flags", 64'({illegal, instret}), 64'd0);
      rst = 1'b1;

      // directed: ADD, LW with 2 waits, BNE not-taken/taken, JAL, I-type
      // add with bit30 set (must stay add), srai, fence NOP
      run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, -1);
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, -1);
      run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b1100011, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, -1);
      run_instr(7'b0001111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);

      // randomized legal instruction stream
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 10);
         run_instr(ops[k], 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(), rnd_bit(), rnd_bit(),
                   $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end

      // reset during a stalled store
      run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 6, 2);
      reset_mid();
      run_instr(7'b0110011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, -1);

      // illegal opcode parks in TRAP until reset
      run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      reset_mid();
      for (int n = 0; n < 20; n++) begin
         k = $urandom_range(0, 10);
         run_instr(ops[k], 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(), rnd_bit(), rnd_bit(),
                   $urandom_range(0, 1), $urandom_range(0, 2), -1);
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
